// File: rtl/esn_fp_pkg.sv
// Shared FP32 constants, FSM state encoding and defaults for the ESN neuron accumulator.
package esn_fp_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP_POS_ZERO = 32'h0000_0000;
  localparam fp32_t FP_NEG_ZERO = 32'h8000_0000;
  localparam fp32_t FP_ONE      = 32'h3F80_0000;

  localparam int ADD_LAT_DEF = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

endpackage

// File: rtl/esn_neuron_acc_if.sv
// Term stream, adder operand/result and sum stream of one ESN neuron accumulator.
interface esn_neuron_acc_if
  import esn_fp_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  fp32_t            in_data;
  logic             in_last;
  fp32_t            add_opa;
  fp32_t            add_opb;
  fp32_t            add_out;
  logic             sum_valid;
  logic             sum_ready;
  fp32_t            sum_data;
  logic [CNT_W-1:0] sum_count;

  // Accumulator side.
  modport slave (
    input  in_valid, in_data, in_last, add_out, sum_ready,
    output in_ready, add_opa, add_opb, sum_valid, sum_data, sum_count
  );

  // Producer, adder and consumer side.
  modport master (
    output in_valid, in_data, in_last, add_out, sum_ready,
    input  in_ready, add_opa, add_opb, sum_valid, sum_data, sum_count
  );

endinterface

// File: rtl/esn_neuron_acc.sv
// Sequential FP32 accumulator: feeds an external pipelined adder one term at a
// time and presents the finished neuron pre-activation sum with a handshake.
module esn_neuron_acc
  import esn_fp_pkg::*;
#(
  parameter int ADD_LAT = ADD_LAT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  esn_neuron_acc_if.slave         bus
);

  localparam int WCNT_W = $clog2(ADD_LAT + 1);
  localparam logic [WCNT_W-1:0] WCNT_END = WCNT_W'(ADD_LAT);

  logic [1:0]        r_state;
  fp32_t             r_acc;
  fp32_t             r_opa;
  fp32_t             r_opb;
  logic              r_last_q;
  logic [WCNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0]  r_elem_cnt;
  logic              r_in_ready;
  logic              r_sum_valid;
  fp32_t             r_sum_data;
  logic [CNT_W-1:0]  r_sum_count;
  logic [CNT_W-1:0]  w_cnt_inc;

  // Element count saturates so very long vectors still report a sane count.
  assign w_cnt_inc = (&r_elem_cnt) ? r_elem_cnt : r_elem_cnt + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= FP_POS_ZERO;
      r_opa       <= FP_POS_ZERO;
      r_opb       <= FP_POS_ZERO;
      r_last_q    <= 1'b0;
      r_wcnt      <= '0;
      r_elem_cnt  <= '0;
      r_in_ready  <= 1'b1;
      r_sum_valid <= 1'b0;
      r_sum_data  <= FP_POS_ZERO;
      r_sum_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_opa      <= r_acc;
            r_opb      <= bus.in_data;
            r_last_q   <= bus.in_last;
            r_wcnt     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt + 1'b1;
          // Operands have been stable for ADD_LAT edges, so add_out is final.
          if (r_wcnt == WCNT_END) begin
            r_acc      <= bus.add_out;
            r_elem_cnt <= w_cnt_inc;
            if (r_last_q) begin
              r_sum_valid <= 1'b1;
              r_sum_data  <= bus.add_out;
              r_sum_count <= w_cnt_inc;
              r_state     <= S_OUT;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
        end
        S_OUT: begin
          if (bus.sum_ready) begin
            r_acc       <= FP_POS_ZERO;
            r_elem_cnt  <= '0;
            r_sum_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.add_opa   = r_opa;
  assign bus.add_opb   = r_opb;
  assign bus.sum_valid = r_sum_valid;
  assign bus.sum_data  = r_sum_data;
  assign bus.sum_count = r_sum_count;

endmodule

// File: tb/tb_esn_neuron_acc.sv
// Bench for esn_neuron_acc: three instances (latency 4, latency 1, narrow counter)
// each driving a behavioural FP32 adder, checked against a real-valued sum model.
module tb_esn_neuron_acc;
  import esn_fp_pkg::*;

  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  fp32_t q_terms[$];

  always #5 clk = ~clk;

  esn_neuron_acc_if #(.CNT_W(16)) bus_a ();
  esn_neuron_acc_if #(.CNT_W(16)) bus_b ();
  esn_neuron_acc_if #(.CNT_W(2))  bus_c ();

  esn_neuron_acc #(.ADD_LAT(LAT_A), .CNT_W(16)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  esn_neuron_acc #(.ADD_LAT(LAT_B), .CNT_W(16)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  esn_neuron_acc #(.ADD_LAT(LAT_B), .CNT_W(2))  u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  // Real-valued conversions; exact for the half-integer values used here.
  function automatic real fp2real(input fp32_t f);
    logic [63:0] b;
    logic [10:0] e11;
    int e;
    if (f[30:0] == 31'd0) return 0.0;
    e = int'(f[30:23]) + 896;
    e11 = e[10:0];
    b = {f[31], e11, f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic fp32_t real2fp(input real r);
    logic [63:0] b;
    logic [7:0] e8;
    int e;
    if (r == 0.0) return FP_POS_ZERO;
    b = $realtobits(r);
    e = int'(b[62:52]) - 896;
    e8 = e[7:0];
    return {b[63], e8, b[51:29]};
  endfunction

  // Behavioural adder: NaN quieting, signed-zero rule under RNE, exact sums otherwise.
  function automatic fp32_t fp_add(input fp32_t a, input fp32_t b);
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return a | 32'h0040_0000;
    if (b[30:23] == 8'hFF && b[22:0] != 23'd0) return b | 32'h0040_0000;
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0)
      return (a[31] & b[31]) ? FP_NEG_ZERO : FP_POS_ZERO;
    return real2fp(fp2real(a) + fp2real(b));
  endfunction

  fp32_t pipe_a [LAT_A];
  fp32_t pipe_b;
  fp32_t pipe_c;

  always @(posedge clk) begin
    pipe_a[0] <= fp_add(bus_a.add_opa, bus_a.add_opb);
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b <= fp_add(bus_b.add_opa, bus_b.add_opb);
    pipe_c <= fp_add(bus_c.add_opa, bus_c.add_opb);
  end

  assign bus_a.add_out = pipe_a[LAT_A-1];
  assign bus_b.add_out = pipe_b;
  assign bus_c.add_out = pipe_c;

  task automatic push_a(input fp32_t d, input logic l);
    int n = 0;
    while (bus_a.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL push_a_timeout in_ready=%b required=1", bus_a.in_ready);
    end
    bus_a.in_valid = 1'b1; bus_a.in_data = d; bus_a.in_last = l;
    @(negedge clk);
    bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
  endtask

  // Counts cycles from the accept edge until in_ready (or sum_valid) rises.
  task automatic wait_done_a(input logic l, output int n);
    n = 0;
    while (((l ? bus_a.sum_valid : bus_a.in_ready) !== 1'b1) && n < 100) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic run_vec_a(input string name);
    int n;
    foreach (q_terms[i]) begin
      push_a(q_terms[i], i == q_terms.size() - 1);
      wait_done_a(i == q_terms.size() - 1, n);
      checks++;
      if (n != LAT_A + 1) begin
        failures++;
        $display("FAIL %s busy_cycles term=%0d got=%0d required=%0d", name, i, n, LAT_A + 1);
      end
    end
  endtask

  task automatic pop_a(input fp32_t exp_d, input int exp_c, input string name);
    checks++;
    if (bus_a.sum_valid !== 1'b1) begin
      failures++; $display("FAIL %s sum_valid got=%b required=1", name, bus_a.sum_valid);
    end
    checks++;
    if (bus_a.sum_data !== exp_d) begin
      failures++; $display("FAIL %s sum_data got=%h required=%h", name, bus_a.sum_data, exp_d);
    end
    checks++;
    if (bus_a.sum_count !== 16'(exp_c)) begin
      failures++; $display("FAIL %s sum_count got=%0d required=%0d", name, bus_a.sum_count, exp_c);
    end
    bus_a.sum_ready = 1'b1;
    @(negedge clk);
    bus_a.sum_ready = 1'b0;
    checks++;
    if (bus_a.sum_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s after_pop valid/ready got=%b%b required=01", name, bus_a.sum_valid, bus_a.in_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus_a.sum_valid !== 1'b0 || bus_a.sum_data !== 32'h0 || bus_a.add_opa !== 32'h0) begin
      failures++;
      $display("FAIL reset_hold valid=%b data=%h opa=%h required=0/0/0", bus_a.sum_valid, bus_a.sum_data, bus_a.add_opa);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_a.in_ready !== 1'b1 || bus_a.add_opa !== 32'h0 || bus_a.add_opb !== 32'h0 ||
        bus_a.sum_count !== 16'd0 || bus_a.sum_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release ready=%b opa=%h opb=%h cnt=%0d valid=%b required=1/0/0/0/0",
               bus_a.in_ready, bus_a.add_opa, bus_a.add_opb, bus_a.sum_count, bus_a.sum_valid);
    end
  endtask

  task automatic test_vector_123();
    q_terms = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    run_vec_a("vec123");
    pop_a(32'h40C0_0000, 3, "vec123");
  endtask

  task automatic test_single();
    q_terms = '{FP_NEG_ZERO};
    run_vec_a("single_negzero");
    pop_a(FP_POS_ZERO, 1, "single_negzero");
    q_terms = '{32'h7FC0_0000};
    run_vec_a("single_nan");
    pop_a(32'h7FC0_0000, 1, "single_nan");
  endtask

  task automatic test_backpressure();
    fp32_t opa_hold;
    fp32_t opb_hold;
    q_terms = '{FP_ONE, 32'h4000_0000};
    run_vec_a("bp_vec");
    opa_hold = bus_a.add_opa;
    opb_hold = bus_a.add_opb;
    bus_a.in_valid = 1'b1; bus_a.in_data = 32'h4120_0000; bus_a.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus_a.sum_valid !== 1'b1 || bus_a.sum_data !== 32'h4040_0000 || bus_a.sum_count !== 16'd2 ||
          bus_a.in_ready !== 1'b0 || bus_a.add_opa !== opa_hold || bus_a.add_opb !== opb_hold) begin
        failures++;
        $display("FAIL backpressure cyc=%0d valid=%b data=%h cnt=%0d ready=%b required=1/40400000/2/0",
                 i, bus_a.sum_valid, bus_a.sum_data, bus_a.sum_count, bus_a.in_ready);
      end
    end
    bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
    pop_a(32'h4040_0000, 2, "bp_vec");
    q_terms = '{32'h3F00_0000, 32'h3F00_0000};
    run_vec_a("bp_after");
    pop_a(FP_ONE, 2, "bp_after");
  endtask

  task automatic test_reset_wait();
    int n;
    push_a(32'h4000_0000, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.add_opa !== 32'h0 || bus_a.add_opb !== 32'h0 || bus_a.sum_valid !== 1'b0 ||
        bus_a.sum_data !== 32'h0 || bus_a.sum_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_wait opa=%h opb=%h valid=%b data=%h cnt=%0d required=all zero",
               bus_a.add_opa, bus_a.add_opb, bus_a.sum_valid, bus_a.sum_data, bus_a.sum_count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_a.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_wait_ready got=%b required=1", bus_a.in_ready);
    end
    n = 0;
    q_terms = '{FP_ONE};
    run_vec_a("after_reset_wait");
    pop_a(FP_ONE, 1, "after_reset_wait");
  endtask

  task automatic test_reset_out();
    q_terms = '{FP_ONE, FP_ONE};
    run_vec_a("reset_out_vec");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.sum_valid !== 1'b0 || bus_a.sum_data !== 32'h0 || bus_a.sum_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_out valid=%b data=%h cnt=%0d required=0/0/0",
               bus_a.sum_valid, bus_a.sum_data, bus_a.sum_count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int v = 0; v < 12; v++) begin
      int len;
      real s;
      len = $urandom_range(1, 6);
      s = 0.0;
      q_terms.delete();
      for (int i = 0; i < len; i++) begin
        int k;
        k = int'($urandom_range(0, 32)) - 16;
        s = s + real'(k) * 0.5;
        q_terms.push_back(real2fp(real'(k) * 0.5));
      end
      run_vec_a("random");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pop_a(real2fp(s), len, "random");
    end
  endtask

  task automatic test_lat1();
    for (int i = 0; i < 8; i++) begin
      int n;
      n = 0;
      while (bus_b.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      bus_b.in_valid = 1'b1; bus_b.in_data = FP_ONE; bus_b.in_last = (i == 7);
      @(negedge clk);
      bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
      n = 0;
      while ((((i == 7) ? bus_b.sum_valid : bus_b.in_ready) !== 1'b1) && n < 100) begin
        @(negedge clk); n++;
      end
      checks++;
      if (n != LAT_B + 1) begin
        failures++;
        $display("FAIL lat1_spacing term=%0d got=%0d required=%0d", i, n, LAT_B + 1);
      end
    end
    checks++;
    if (bus_b.sum_valid !== 1'b1 || bus_b.sum_data !== 32'h4100_0000 || bus_b.sum_count !== 16'd8) begin
      failures++;
      $display("FAIL lat1_sum valid=%b data=%h cnt=%0d required=1/41000000/8",
               bus_b.sum_valid, bus_b.sum_data, bus_b.sum_count);
    end
    bus_b.sum_ready = 1'b1; @(negedge clk); bus_b.sum_ready = 1'b0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      int n;
      n = 0;
      while (bus_c.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      bus_c.in_valid = 1'b1; bus_c.in_data = FP_ONE; bus_c.in_last = (i == 4);
      @(negedge clk);
      bus_c.in_valid = 1'b0; bus_c.in_last = 1'b0;
    end
    begin
      int n;
      n = 0;
      while (bus_c.sum_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    end
    checks++;
    if (bus_c.sum_valid !== 1'b1 || bus_c.sum_data !== 32'h40A0_0000 || bus_c.sum_count !== 2'd3) begin
      failures++;
      $display("FAIL saturation valid=%b data=%h cnt=%0d required=1/40a00000/3",
               bus_c.sum_valid, bus_c.sum_data, bus_c.sum_count);
    end
    bus_c.sum_ready = 1'b1; @(negedge clk); bus_c.sum_ready = 1'b0;
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_last = 1'b0; bus_a.sum_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_last = 1'b0; bus_b.sum_ready = 1'b0;
    bus_c.in_valid = 1'b0; bus_c.in_data = '0; bus_c.in_last = 1'b0; bus_c.sum_ready = 1'b0;
    test_reset();
    test_vector_123();
    test_single();
    test_backpressure();
    test_reset_wait();
    test_reset_out();
    test_random();
    test_lat1();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time_limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/esn_neuron_acc.md
Name: esn_neuron_acc

Overview:
- Sequential FP32 accumulator that sits directly upstream and downstream of the `add` single-precision adder. It drives `add`'s opa/opb and consumes its out.
- Sums a stream of FP32 terms, the weighted reservoir inputs of one ESN neuron, into a single pre-activation value.
- Holds the running sum, issues one addition per input term, waits out the adder pipeline, and presents the final sum with a valid/ready handshake.
- The adder is instantiated outside this block, alongside it.

Parameters:
- ADD_LAT, 4, adder pipeline latency in clk cycles; must be ≥ the true `add` latency and ≥ 1.
- CNT_W, 16, width of the element counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  term valid.
- in_ready  out  1  block can accept a term.
- in_data  in  32  FP32 term.
- in_last  in  1  term is the final one of the vector.
- add_opa  out  32  running-sum operand to the adder.
- add_opb  out  32  term operand to the adder.
- add_out  in  32  adder result.
- sum_valid  out  1  final sum available.
- sum_ready  in  1  consumer takes the sum.
- sum_data  out  32  final FP32 sum.
- sum_count  out  CNT_W  number of terms summed.

Behaviour:
- Reset (async assert, sync release):
  - state = S_IDLE.
  - acc, add_opa, add_opb, sum_data = 32'h0000_0000.
  - cnt, sum_count = 0; sum_valid = 0; last_q = 0.
  - in_ready = 1 in the first cycle after release.
- States: S_IDLE, S_WAIT, S_OUT (shared encoding).
- S_IDLE:
  - in_ready = 1.
  - On in_valid & in_ready (accept edge E0): add_opa <= acc; add_opb <= in_data; last_q <= in_last; wcnt <= 0; go S_WAIT.
- S_WAIT:
  - in_ready = 0.
  - add_opa/add_opb stay stable for the whole state.
  - wcnt increments every cycle.
  - On the edge where wcnt == ADD_LAT (the (ADD_LAT+1)th edge after E0): acc <= add_out; elem_cnt <= elem_cnt+1, saturating at all-ones.
  - At that edge, next state is S_OUT if last_q, else S_IDLE.
  - Throughput is one term per ADD_LAT+2 cycles.
- S_OUT:
  - sum_valid = 1; in_ready = 0.
  - sum_data = acc; sum_count = elem_cnt. Both are held stable while sum_ready = 0.
  - On sum_ready: acc <= +0 (32'h0); elem_cnt <= 0; sum_valid deasserts the next cycle; go S_IDLE.
- Arithmetic:
  - The block performs no FP arithmetic itself; add_out is taken verbatim.
  - NaN, Inf and denormal results propagate as the adder produces them.
  - Every vector starts from acc = +0, so a single-term vector returns 0+x: -0 becomes +0 under round-to-nearest-even, all other x return x.
- in_valid while in_ready = 0: ignored. Upstream must hold in_data, in_valid and in_last until accepted.
- in_last on the first term: valid one-term vector, sum_count = 1.
- Counter saturation: sum_count saturates at 2^CNT_W-1; the sum itself stays correct.
- Reset mid-operation (S_WAIT or S_OUT): partial sum and count are discarded; all outputs return to reset values; the in-flight adder result is ignored.
- sum_ready while sum_valid = 0: no effect.
- All outputs are registered; there is no combinational path from in_* to sum_*, or from add_out to any output.

Decomposition:
- Package esn_fp_pkg:
  - FP32 constants: FP_POS_ZERO = 32'h0000_0000, FP_NEG_ZERO, FP_ONE.
  - State encoding: S_IDLE, S_WAIT, S_OUT.
  - Default ADD_LAT.
- Single flat module; no sub-module needed.
- Top level instantiates `add` next to this block and wires add_opa/add_opb/add_out to it.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle → outputs immediately zero and sum_valid = 0; after release, in_ready = 1 and add_opa = add_opb = 0.
- Vector {0x3F800000, 0x40000000, 0x40400000} (1, 2, 3), in_last on the 3rd → sum_data = 0x40C00000, sum_count = 3. in_ready is low exactly ADD_LAT+1 cycles after each accept. sum_valid rises on the edge after the 3rd capture.
- Single term 0x80000000 (-0) with in_last → sum_data = 0x00000000, sum_count = 1. Single term 0x7FC00000 → 0x7FC00000.
- Backpressure: hold sum_ready = 0 for 5 cycles → sum_valid, sum_data and sum_count stable, in_ready = 0, in_valid ignored. Then the next vector {0x3F000000, 0x3F000000} → 0x3F800000, count 2, proving acc was cleared.
- Reset in S_WAIT after accepting 0x40000000 → outputs zero. Next vector {0x3F800000}+last → 0x3F800000, count 1.
- ADD_LAT = 1 build, with a bench adder model of latency 1: 8 terms of 0x3F800000 → 0x41000000, count 8, accepts spaced 3 cycles.
